// File: rtl/cbus_ram_responder_pkg.sv
`default_nettype none
// cbus_ram_responder_pkg: CBus request/response types and responder FSM states.
// Revision 1.0
package cbus_ram_responder_pkg;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
    MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
    MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
    MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    logic [2:0]      size;
    logic [63:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    BURST   = 2'd2,
    RECOVER = 2'd3
  } cbus_rsp_state_t;

endpackage
`default_nettype wire

// File: rtl/cbus_ram_array.sv
`default_nettype none
// cbus_ram_array: 64-bit word array, combinational read, byte-strobed synchronous write.
// Revision 1.0
module cbus_ram_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned IDX_W       = 12
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [7:0]       strb_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      rdata_o
);

  logic [63:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (strb_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/cbus_ram_responder.sv
`default_nettype none
// cbus_ram_responder: synthesizable CBus memory responder with fixed latency, bursts and byte strobes.
// Revision 1.0
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  oreq,
  output cbus_resp_t oresp
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  cbus_rsp_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       beat_q, beat_d;
  logic [3:0]       lat_q, lat_d;
  mlen_t            len_q, len_d;
  axi_burst_type_t  burst_q, burst_d;
  logic             wr_q, wr_d;
  logic             inr_q, inr_d;

  logic [63:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] start_idx;
  logic             we;
  logic [63:0]      rdata;
  logic             unused_size;

  // Range is decided once at acceptance and held for every beat of the burst.
  assign offset      = oreq.addr - BASE_ADDR;
  assign in_range    = (oreq.addr >= BASE_ADDR) && (offset < SPAN);
  assign start_idx   = offset[3 +: IDX_W];
  assign unused_size = ^oreq.size;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      len_q   <= MLEN1;
      burst_q <= FIXED;
      wr_q    <= 1'b0;
      inr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      wr_q    <= wr_d;
      inr_q   <= inr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    len_d   = len_q;
    burst_d = burst_q;
    wr_d    = wr_q;
    inr_d   = inr_q;
    oresp   = '0;
    we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (oreq.valid) begin
          idx_d   = start_idx;
          len_d   = oreq.len;
          burst_d = oreq.burst;
          wr_d    = oreq.is_write;
          inr_d   = in_range;
          beat_d  = '0;
          lat_d   = '0;
          state_d = (LATENCY > 0) ? WAIT : BURST;
        end
      end

      WAIT: begin
        if (!oreq.valid) begin
          state_d = IDLE;
        end else if (lat_q == LAT_LAST) begin
          state_d = BURST;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      BURST: begin
        oresp.ready = 1'b1;
        oresp.last  = (beat_q == 4'(len_q));
        oresp.data  = (!wr_q && inr_q) ? rdata : 64'h0;
        // A beat presented without valid is a protocol abort and is not performed.
        if (!oreq.valid) begin
          state_d = IDLE;
        end else begin
          we = wr_q && inr_q;
          if (beat_q == 4'(len_q)) begin
            state_d = RECOVER;
          end else begin
            beat_d = beat_q + 4'd1;
            if (burst_q == INCR) begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end

      RECOVER: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  cbus_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (we && !reset),
    .addr_i  (idx_q),
    .strb_i  (oreq.strobe),
    .wdata_i (oreq.data),
    .rdata_o (rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_cbus_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_cbus_ram_responder: randomized self-checking bench against a word-array reference model.
// Revision 1.0
module tb_cbus_ram_responder;
  import cbus_ram_responder_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int unsigned LAT   = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  cbus_ram_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .oreq  (oreq),
    .oresp (oresp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] mdl [DEPTH];
  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];
  logic [63:0] obs_data [16];
  logic        obs_last [16];
  int          obs_lat;
  int          obs_beats;
  logic        obs_after;

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 8);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'(((a - BASE) >> 3) % DEPTH);
  endfunction

  function automatic int beat_idx(input logic [63:0] a, input bit fixed, input int b);
    return fixed ? widx(a) : (widx(a) + b) % DEPTH;
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a, input bit fixed, input int b);
    return in_rng(a) ? mdl[beat_idx(a, fixed, b)] : 64'h0;
  endfunction

  function automatic void model_write(input logic [63:0] a, input bit fixed, input int done);
    if (!in_rng(a)) return;
    for (int b = 0; b < done; b++) begin
      for (int l = 0; l < 8; l++) begin
        if (wr_strb[b][l]) mdl[beat_idx(a, fixed, b)][8*l +: 8] = wr_data[b][8*l +: 8];
      end
    end
  endfunction

  // Drives one transaction; request fields other than valid/data/strobe are scrambled once accepted.
  task automatic run_txn(input bit wr, input logic [63:0] addr, input int n,
                         input bit fixed, input int rst_beat);
    bit done;
    done      = 1'b0;
    obs_beats = 0;
    obs_lat   = -1;
    obs_after = 1'bx;
    for (int i = 0; i < 16; i++) begin
      obs_data[i] = '0;
      obs_last[i] = 1'b0;
    end
    @(negedge clk);
    oreq.valid    = 1'b1;
    oreq.is_write = wr;
    oreq.size     = 3'd3;
    oreq.addr     = addr;
    oreq.len      = mlen_t'(n - 1);
    oreq.burst    = fixed ? FIXED : INCR;
    oreq.data     = wr_data[0];
    oreq.strobe   = wr_strb[0];
    for (int k = 1; k <= 64 && !done; k++) begin
      @(negedge clk);
      if (obs_beats < 16) begin
        oreq.data   = wr_data[obs_beats];
        oreq.strobe = wr_strb[obs_beats];
      end
      oreq.addr     = {$urandom, $urandom};
      oreq.len      = mlen_t'($urandom_range(0, 15));
      oreq.burst    = axi_burst_type_t'($urandom_range(0, 1));
      oreq.is_write = 1'($urandom_range(0, 1));
      if (oresp.ready) begin
        if (obs_lat < 0) obs_lat = k;
        if (obs_beats < 16) begin
          obs_data[obs_beats] = oresp.data;
          obs_last[obs_beats] = oresp.last;
        end
        if (obs_beats == rst_beat) begin
          reset = 1'b1;
          @(negedge clk);
          obs_after  = oresp.ready;
          reset      = 1'b0;
          oreq.valid = 1'b0;
          done       = 1'b1;
        end else begin
          obs_beats++;
          if (oresp.last) begin
            @(negedge clk);
            obs_after  = oresp.ready | oresp.last;
            oreq.valid = 1'b0;
            done       = 1'b1;
          end
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: beats=%0d of required %0d", obs_beats, n);
      oreq.valid = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    oreq  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (oresp !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", oresp);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (oresp !== '0) begin
      errors++;
      $display("FAIL idle_outputs: got %h want 0", oresp);
    end
  endtask

  task automatic test_fill();
    for (int c = 0; c < int'(DEPTH) / 16; c++) begin
      for (int b = 0; b < 16; b++) begin
        wr_data[b] = {$urandom, $urandom};
        wr_strb[b] = 8'hFF;
      end
      run_txn(1'b1, BASE + 64'(c * 128), 16, 1'b0, -1);
      model_write(BASE + 64'(c * 128), 1'b0, 16);
      checks++;
      if (obs_beats != 16 || obs_lat != int'(LAT) + 1) begin
        errors++;
        $display("FAIL fill_write: beats=%0d lat=%0d want 16/%0d", obs_beats, obs_lat, LAT + 1);
      end
    end
  endtask

  task automatic test_single_read();
    wr_data[0] = 64'h1122_3344_5566_7788;
    wr_strb[0] = 8'hFF;
    run_txn(1'b1, BASE, 1, 1'b0, -1);
    model_write(BASE, 1'b0, 1);
    run_txn(1'b0, BASE, 1, 1'b0, -1);
    checks++;
    if (obs_lat != 3) begin
      errors++;
      $display("FAIL single_latency: got %0d want 3", obs_lat);
    end
    checks++;
    if (obs_data[0] !== 64'h1122_3344_5566_7788 || obs_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_data: got %h last=%b want 1122334455667788 last=1", obs_data[0], obs_last[0]);
    end
    checks++;
    if (obs_after !== 1'b0) begin
      errors++;
      $display("FAIL single_recover: got ready|last=%b want 0", obs_after);
    end
  endtask

  task automatic test_strobe();
    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_strb[0] = 8'hFF;
    run_txn(1'b1, BASE + 64'h10, 1, 1'b0, -1);
    model_write(BASE + 64'h10, 1'b0, 1);
    wr_data[0] = 64'h0;
    wr_strb[0] = 8'h0F;
    run_txn(1'b1, BASE + 64'h10, 1, 1'b0, -1);
    model_write(BASE + 64'h10, 1'b0, 1);
    run_txn(1'b0, BASE + 64'h10, 1, 1'b0, -1);
    checks++;
    if (obs_data[0] !== 64'hFFFF_FFFF_0000_0000) begin
      errors++;
      $display("FAIL strobe_merge: got %h want ffffffff00000000", obs_data[0]);
    end
  endtask

  task automatic test_incr16();
    for (int k = 0; k < 16; k++) begin
      wr_data[k] = 64'(k);
      wr_strb[k] = 8'hFF;
    end
    run_txn(1'b1, BASE + 64'h100, 16, 1'b0, -1);
    model_write(BASE + 64'h100, 1'b0, 16);
    run_txn(1'b0, BASE + 64'h100, 16, 1'b0, -1);
    checks++;
    if (obs_beats != 16) begin
      errors++;
      $display("FAIL incr16_beats: got %0d want 16", obs_beats);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs_data[k] !== 64'(k) || obs_last[k] !== (k == 15)) begin
        errors++;
        $display("FAIL incr16_beat%0d: got %h last=%b want %h last=%b", k, obs_data[k], obs_last[k], 64'(k), (k == 15));
      end
    end
  endtask

  task automatic test_wrap_fixed();
    int exp_idx [4];
    exp_idx = '{62, 63, 0, 1};
    run_txn(1'b0, BASE + 64'(8 * 62), 4, 1'b0, -1);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs_data[b] !== mdl[exp_idx[b]]) begin
        errors++;
        $display("FAIL wrap_beat%0d: got %h want %h", b, obs_data[b], mdl[exp_idx[b]]);
      end
    end
    for (int b = 0; b < 4; b++) begin
      wr_data[b] = 64'(b + 1);
      wr_strb[b] = 8'hFF;
    end
    run_txn(1'b1, BASE + 64'(8 * 5), 4, 1'b1, -1);
    mdl[5] = 64'd4;
    run_txn(1'b0, BASE + 64'(8 * 5), 1, 1'b0, -1);
    checks++;
    if (obs_data[0] !== 64'd4) begin
      errors++;
      $display("FAIL fixed_write: got %h want 4", obs_data[0]);
    end
  endtask

  task automatic test_out_of_range();
    run_txn(1'b0, 64'h7FFF_FFF8, 4, 1'b0, -1);
    checks++;
    if (obs_lat != 3 || obs_beats != 4 || obs_after !== 1'b0) begin
      errors++;
      $display("FAIL oor_read_timing: lat=%0d beats=%0d after=%b want 3/4/0", obs_lat, obs_beats, obs_after);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs_data[b] !== 64'h0 || obs_last[b] !== (b == 3)) begin
        errors++;
        $display("FAIL oor_read_beat%0d: got %h last=%b want 0 last=%b", b, obs_data[b], obs_last[b], (b == 3));
      end
    end
    wr_data[0] = ~mdl[0];
    wr_strb[0] = 8'hFF;
    run_txn(1'b1, BASE + 64'(8 * DEPTH), 1, 1'b0, -1);
    model_write(BASE + 64'(8 * DEPTH), 1'b0, 1);
    run_txn(1'b0, BASE, 1, 1'b0, -1);
    checks++;
    if (obs_data[0] !== mdl[0]) begin
      errors++;
      $display("FAIL oor_write_discard: got %h want %h", obs_data[0], mdl[0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 8; b++) begin
      wr_data[b] = {$urandom, $urandom};
      wr_strb[b] = 8'hFF;
    end
    run_txn(1'b1, BASE + 64'(8 * 8), 8, 1'b0, 3);
    model_write(BASE + 64'(8 * 8), 1'b0, 3);
    checks++;
    if (obs_after !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b want 0", obs_after);
    end
    run_txn(1'b0, BASE + 64'(8 * 8), 8, 1'b0, -1);
    checks++;
    if (obs_lat != int'(LAT) + 1 || obs_beats != 8) begin
      errors++;
      $display("FAIL reset_mid_next: lat=%0d beats=%0d want %0d/8", obs_lat, obs_beats, LAT + 1);
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (obs_data[b] !== mdl[8 + b]) begin
        errors++;
        $display("FAIL reset_mid_word%0d: got %h want %h", 8 + b, obs_data[b], mdl[8 + b]);
      end
    end
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    oreq.valid = 1'b1; oreq.is_write = 1'b0; oreq.addr = BASE; oreq.len = MLEN4; oreq.burst = INCR;
    @(negedge clk);
    oreq.valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (oresp.ready !== 1'b0) begin
        errors++;
        $display("FAIL abort_wait_cycle%0d: ready=%b want 0", k, oresp.ready);
      end
    end
    oreq.valid = 1'b1; oreq.is_write = 1'b1; oreq.addr = BASE + 64'(8 * 20);
    oreq.data = ~mdl[20]; oreq.strobe = 8'hFF;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (oresp.ready) begin
        seen = 1'b1;
        oreq.valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (!seen || oresp.ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_burst: seen=%0d ready=%b want seen=1 ready=0", seen, oresp.ready);
    end
    run_txn(1'b0, BASE + 64'(8 * 20), 1, 1'b0, -1);
    checks++;
    if (obs_data[0] !== mdl[20]) begin
      errors++;
      $display("FAIL abort_no_write: got %h want %h", obs_data[0], mdl[20]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    logic [63:0] want;
    bit          wr;
    bit          fixed;
    int          n;
    for (int t = 0; t < 24; t++) begin
      wr    = 1'($urandom_range(0, 1));
      fixed = 1'($urandom_range(0, 1));
      n     = $urandom_range(1, 16);
      case ($urandom_range(0, 5))
        0:       a = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
        1:       a = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 4)) + 64'($urandom_range(0, 7));
        default: a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(0, 7));
      endcase
      for (int b = 0; b < 16; b++) begin
        wr_data[b] = {$urandom, $urandom};
        wr_strb[b] = 8'($urandom);
      end
      run_txn(wr, a, n, fixed, -1);
      checks++;
      if (obs_lat != int'(LAT) + 1 || obs_beats != n || obs_after !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_timing: lat=%0d beats=%0d after=%b want %0d/%0d/0", t, obs_lat, obs_beats, obs_after, LAT + 1, n);
      end
      for (int b = 0; b < n; b++) begin
        want = wr ? 64'h0 : model_read(a, fixed, b);
        checks++;
        if (obs_data[b] !== want || obs_last[b] !== (b == n - 1)) begin
          errors++;
          $display("FAIL b2b%0d_beat%0d: got %h last=%b want %h last=%b", t, b, obs_data[b], obs_last[b], want, (b == n - 1));
        end
      end
      if (wr) model_write(a, fixed, n);
    end
  endtask

  task automatic test_readback();
    for (int c = 0; c < int'(DEPTH) / 16; c++) begin
      run_txn(1'b0, BASE + 64'(c * 128), 16, 1'b0, -1);
      for (int b = 0; b < 16; b++) begin
        checks++;
        if (obs_data[b] !== mdl[c * 16 + b]) begin
          errors++;
          $display("FAIL readback_word%0d: got %h want %h", c * 16 + b, obs_data[b], mdl[c * 16 + b]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int b = 0; b < 16; b++) begin
      wr_data[b] = '0;
      wr_strb[b] = '0;
    end
    test_reset();
    test_fill();
    test_single_read();
    test_strobe();
    test_incr16();
    test_wrap_fixed();
    test_out_of_range();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    test_readback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
